// File: rtl/ann_frame_loader_if.sv
// Sample stream, detector and result signals shared by ann_frame_loader and its neighbours.
// The loader connects through the slave modport; the source/detector side uses master.
interface ann_frame_loader_if #(
   parameter int unsigned FEAT_N = 30,
   parameter int unsigned W      = 10,
   parameter int unsigned OUT_N  = 3
);
   logic [W-1:0]                  sample_in;
   logic                          sample_valid;
   logic                          sample_ready;
   logic                          train_req;
   logic [FEAT_N-1:0][W-1:0]      frame_out;
   logic [OUT_N-1:0][W-1:0]       target_out;
   logic                          det_start;
   logic                          det_train;
   logic                          det_done;
   logic [OUT_N-1:0][W-1:0]       det_out;
   logic [1:0]                    result_class;
   logic [W-1:0]                  result_value;
   logic                          result_valid;
   logic                          busy;
   logic                          timeout_err;

   modport slave (
      input  sample_in, sample_valid, train_req, det_done, det_out,
      output sample_ready, frame_out, target_out, det_start, det_train,
             result_class, result_value, result_valid, busy, timeout_err
   );

   modport master (
      output sample_in, sample_valid, train_req, det_done, det_out,
      input  sample_ready, frame_out, target_out, det_start, det_train,
             result_class, result_value, result_valid, busy, timeout_err
   );
endinterface

// File: rtl/ann_frame_loader.sv
// Collects a streamed feature (and optional target) frame, launches the detector, and
// reports the argmax of its outputs, with a bounded wait for the detector's answer.
module ann_frame_loader #(
   parameter int unsigned FEAT_N  = 30,
   parameter int unsigned W       = 10,
   parameter int unsigned OUT_N   = 3,
   parameter int unsigned TIMEOUT = 1023
) (
   input logic               Clock,
   input logic               Rst,
   ann_frame_loader_if.slave bus
);
   localparam int unsigned LenMax = FEAT_N + OUT_N;
   localparam int unsigned IW     = $clog2(LenMax + 1);
   localparam int unsigned TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

   typedef enum logic [2:0] {StIdle, StLoad, StLaunch, StWait, StCapture} state_e;

   state_e        state_q;
   logic          mode_q;
   logic [IW-1:0] idx_q;
   logic [TW-1:0] timer_q;
   logic          xfer;
   logic [IW-1:0] last_idx;
   logic [1:0]    best_idx;
   logic [W-1:0]  best_val;

   assign xfer     = bus.sample_valid & bus.sample_ready;
   assign last_idx = mode_q ? IW'(LenMax - 1) : IW'(FEAT_N - 1);

   assign bus.sample_ready = (state_q == StIdle) || (state_q == StLoad);
   assign bus.busy         = state_q != StIdle;
   assign bus.det_start    = state_q == StLaunch;
   assign bus.det_train    = mode_q & (state_q inside {StLaunch, StWait, StCapture});
   assign bus.result_valid = state_q == StCapture;

   // Strict compare keeps the lowest index on ties.
   always_comb begin
      best_idx = '0;
      best_val = bus.det_out[0];
      for (int k = 1; k < OUT_N; k++) begin
         if (bus.det_out[k] > best_val) begin
            best_val = bus.det_out[k];
            best_idx = 2'(k);
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         state_q          <= StIdle;
         mode_q           <= 1'b0;
         idx_q            <= '0;
         timer_q          <= '0;
         bus.frame_out    <= '0;
         bus.target_out   <= '0;
         bus.result_class <= '0;
         bus.result_value <= '0;
         bus.timeout_err  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (xfer) begin
                  bus.frame_out[0] <= bus.sample_in;
                  mode_q           <= bus.train_req;
                  idx_q            <= IW'(1);
                  state_q          <= StLoad;
               end
            end
            StLoad: begin
               if (xfer) begin
                  for (int i = 0; i < FEAT_N; i++) begin
                     if (idx_q == IW'(i)) bus.frame_out[i] <= bus.sample_in;
                  end
                  for (int j = 0; j < OUT_N; j++) begin
                     if (idx_q == IW'(FEAT_N + j)) bus.target_out[j] <= bus.sample_in;
                  end
                  if (idx_q == last_idx) begin
                     idx_q   <= '0;
                     state_q <= StLaunch;
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
            end
            StLaunch: begin
               timer_q <= '0;
               state_q <= StWait;
            end
            StWait: begin
               // A done arriving on the timeout cycle still counts as a result.
               if (bus.det_done) begin
                  bus.result_class <= best_idx;
                  bus.result_value <= best_val;
                  state_q          <= StCapture;
               end else if (timer_q == TimeoutVal) begin
                  bus.timeout_err <= 1'b1;
                  state_q         <= StIdle;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            StCapture: state_q <= StIdle;
            default:   state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_ann_frame_loader.sv
// Scoreboard bench for ann_frame_loader: drives frames, plays the detector, and checks
// frames, launch pulses, argmax results, timeout and reset behaviour.
module tb_ann_frame_loader;
   localparam int unsigned FEAT_N  = 30;
   localparam int unsigned W       = 10;
   localparam int unsigned OUT_N   = 3;
   localparam int unsigned TIMEOUT = 1023;
   localparam int unsigned CW      = 512;

   typedef logic [OUT_N-1:0][W-1:0] vec_t;
   typedef struct packed {
      logic [1:0]   cls;
      logic [W-1:0] val;
      logic         train;
   } exp_t;

   logic Clock = 1'b0;
   logic Rst   = 1'b1;
   always #5 Clock = ~Clock;

   ann_frame_loader_if #(.FEAT_N(FEAT_N), .W(W), .OUT_N(OUT_N)) bus ();

   ann_frame_loader #(.FEAT_N(FEAT_N), .W(W), .OUT_N(OUT_N), .TIMEOUT(TIMEOUT)) dut (
      .Clock (Clock),
      .Rst   (Rst),
      .bus   (bus)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   int   starts   = 0;
   int   results  = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [FEAT_N-1:0][W-1:0] m_frame  = '0;
   vec_t                     m_target = '0;
   logic                     m_err    = 1'b0;

   task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input vec_t d, input bit tr);
      exp_t e;
      e.cls   = '0;
      e.val   = d[0];
      e.train = tr;
      for (int k = 1; k < OUT_N; k++) begin
         if (d[k] > e.val) begin
            e.val = d[k];
            e.cls = 2'(k);
         end
      end
      return e;
   endfunction

   function automatic vec_t mk(input int a, input int b, input int c);
      vec_t v;
      v[0] = W'(a);
      v[1] = W'(b);
      v[2] = W'(c);
      return v;
   endfunction

   // Result monitor: every result pulse must match the oldest expected entry.
   always @(negedge Clock) begin
      if (bus.det_start) starts++;
      if (bus.result_valid) begin
         results++;
         if (exp_q.size() == 0) begin
            check_eq("spurious_result", bus.result_valid, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("result_class", bus.result_class, mon_e.cls);
            check_eq("result_value", bus.result_value, mon_e.val);
            check_eq("det_train_capture", bus.det_train, mon_e.train);
         end
      end
   end

   task automatic send_words(input bit train, input int n_words, input int base, input vec_t tgt,
                             input bit stall, output int accepted);
      int i   = 0;
      int cyc = 0;
      accepted = 0;
      while (i < n_words && cyc < 500) begin
         @(negedge Clock);
         cyc++;
         if (stall && (cyc % 2 == 0)) begin
            bus.sample_valid = 1'b0;
         end else begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = (i < FEAT_N) ? W'(base + i) : tgt[i - FEAT_N];
            bus.train_req    = (i == 0) ? train : ~train;
            if (bus.sample_ready) begin
               if (i < FEAT_N) m_frame[i] = bus.sample_in;
               else m_target[i - FEAT_N] = bus.sample_in;
               i++;
               accepted++;
            end
         end
      end
   endtask

   task automatic run_frame(input bit train, input int base, input vec_t tgt, input bit stall,
                            input bit hold, input vec_t dout, input bit timeout);
      int n_words = train ? FEAT_N + OUT_N : FEAT_N;
      int acc;
      int s0 = starts;
      int r0 = results;
      int c  = 0;
      send_words(train, n_words, base, tgt, stall, acc);
      check_eq("words_accepted", acc, n_words);
      @(negedge Clock);
      bus.sample_valid = hold;
      bus.sample_in    = '1;
      check_eq("det_start", bus.det_start, 1);
      check_eq("ready_after_last", bus.sample_ready, 0);
      check_eq("det_train_launch", bus.det_train, train);
      check_eq("frame_out", bus.frame_out, m_frame);
      check_eq("target_out", bus.target_out, m_target);
      check_eq("timeout_err_pre", bus.timeout_err, m_err);
      if (!timeout) begin
         repeat (5) @(negedge Clock);
         check_eq("det_train_wait", bus.det_train, train);
         bus.det_out  = dout;
         bus.det_done = 1'b1;
         exp_q.push_back(model(dout, train));
         @(negedge Clock);
         bus.det_done = 1'b0;
         while (!bus.result_valid && c < 20) begin
            @(negedge Clock);
            c++;
         end
         check_eq("result_seen", bus.result_valid, 1);
         bus.sample_valid = 1'b0;
      end else begin
         while (!bus.timeout_err && c < TIMEOUT + 20) begin
            @(negedge Clock);
            c++;
         end
         check_eq("timeout_window", (c >= TIMEOUT + 1 && c <= TIMEOUT + 2), 1);
         check_eq("busy_after_timeout", bus.busy, 0);
         m_err = 1'b1;
      end
      repeat (3) @(negedge Clock);
      check_eq("start_pulses", starts - s0, 1);
      check_eq("result_pulses", results - r0, timeout ? 0 : 1);
      check_eq("det_train_idle", bus.det_train, 0);
      check_eq("frame_hold", bus.frame_out, m_frame);
      check_eq("timeout_err_post", bus.timeout_err, m_err);
   endtask

   task automatic pulse_reset();
      @(negedge Clock);
      Rst              = 1'b1;
      bus.sample_valid = 1'b0;
      @(negedge Clock);
      Rst      = 1'b0;
      m_frame  = '0;
      m_target = '0;
      m_err    = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_ready"}, bus.sample_ready, 1);
      check_eq({tag, "_busy"}, bus.busy, 0);
      check_eq({tag, "_start"}, bus.det_start, 0);
      check_eq({tag, "_train"}, bus.det_train, 0);
      check_eq({tag, "_rvalid"}, bus.result_valid, 0);
      check_eq({tag, "_rclass"}, bus.result_class, 0);
      check_eq({tag, "_rvalue"}, bus.result_value, 0);
      check_eq({tag, "_err"}, bus.timeout_err, 0);
      check_eq({tag, "_frame"}, bus.frame_out, 0);
      check_eq({tag, "_target"}, bus.target_out, 0);
   endtask

   initial begin
      int acc;
      int r0;
      bus.sample_in    = '0;
      bus.sample_valid = 1'b0;
      bus.train_req    = 1'b0;
      bus.det_done     = 1'b0;
      bus.det_out      = '0;
      repeat (3) @(negedge Clock);
      Rst = 1'b0;
      check_reset_state("reset");

      run_frame(1'b0, 1, '0, 1'b0, 1'b0, mk(100, 700, 300), 1'b0);
      run_frame(1'b1, 101, mk(900, 50, 50), 1'b0, 1'b0, mk(5, 9, 9), 1'b0);
      run_frame(1'b0, 200, '0, 1'b1, 1'b1, mk(500, 500, 200), 1'b0);
      run_frame(1'b0, 300, '0, 1'b0, 1'b0, mk(0, 0, 0), 1'b0);
      run_frame(1'b0, 350, '0, 1'b0, 1'b0, '0, 1'b1);
      run_frame(1'b0, 500, '0, 1'b0, 1'b0, mk(10, 20, 1023), 1'b0);

      // Reset after 17 words of a training frame.
      send_words(1'b1, 17, 700, '0, 1'b0, acc);
      pulse_reset();
      check_reset_state("rst_mid_frame");
      run_frame(1'b0, 400, '0, 1'b0, 1'b0, mk(1, 2, 3), 1'b0);

      // Reset while waiting on the detector; a late done must not produce a result.
      r0 = results;
      send_words(1'b1, FEAT_N + OUT_N, 800, mk(7, 8, 9), 1'b0, acc);
      @(negedge Clock);
      bus.sample_valid = 1'b0;
      repeat (3) @(negedge Clock);
      pulse_reset();
      check_reset_state("rst_mid_wait");
      bus.det_out  = mk(1, 1, 1);
      bus.det_done = 1'b1;
      @(negedge Clock);
      bus.det_done = 1'b0;
      repeat (3) @(negedge Clock);
      check_eq("no_result_after_reset", results - r0, 0);
      check_eq("idle_after_late_done", bus.busy, 0);

      run_frame(1'b0, 600, '0, 1'b0, 1'b0, mk(7, 3, 7), 1'b0);
      check_eq("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
